mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits directly downstream of `register_file` and takes its two operands from the `read_data_1` and `read_data_2` ports. It executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and holds the 2×WIDTH result in HI/LO, where MFHI/MFLO read it back toward the register-file `write_data` path. The core stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request an operation; accepted only in IDLE.
- `op`  in  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_a`  in  WIDTH: rs value (multiplicand / dividend).
- `operand_b`  in  WIDTH: rt value (multiplier / divisor).
- `hi_we`  in  1: MTHI; load `wr_data` into HI.
- `lo_we`  in  1: MTLO; load `wr_data` into LO.
- `wr_data`  in  WIDTH: data for MTHI/MTLO.
- `hi`  out  WIDTH: HI register (MFHI source).
- `lo`  out  WIDTH: LO register (MFLO source).
- `busy`  out  1: operation in progress; core must stall MF*/MT*/new MD ops.
- `done`  out  1: one-cycle pulse in the cycle HI/LO first show a new result.

## Operation
- **FSM states:** IDLE → CALC → FIX → IDLE.
- **IDLE:**
  - `start`=1: latch `op`. Latch |a| and |b| for signed ops, raw values for unsigned. Record the result sign (a_sign^b_sign) and the remainder sign (a_sign). Clear the iteration counter. Go to CALC.
- **CALC:** WIDTH cycles, one bit per cycle, in internal working registers.
  - Multiply: shift-add, 2×WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter runs 0..WIDTH-1; leave to FIX when the counter equals WIDTH-1.
- **FIX:** one cycle.
  - Apply sign correction.
    - Multiply: negate the full 2×WIDTH product if the result sign is 1.
    - Divide: negate the quotient if the result sign is 1; negate the remainder if the remainder sign is 1.
  - Write HI/LO.
    - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0].
    - DIV/DIVU: LO = quotient, HI = remainder.
  - Assert `done`; return to IDLE.
- **Arithmetic rules:** all arithmetic is modulo 2^WIDTH per half. Negation is two's complement.
- **Divide by zero** (`operand_b`=0): same latency. LO = all ones, HI = dividend after the sign rule, which equals `operand_a`.
- **Signed overflow** (MIN_INT / -1): LO = 0x80000000, HI = 0. This falls out of the absolute-value method; no special case is needed.
- **HI/LO during CALC:** `hi`/`lo` hold their previous values until FIX.
- **MTHI/MTLO:**
  - Applied only in IDLE.
  - Ignored while `busy`.
  - If `start` and `hi_we`/`lo_we` arrive in the same IDLE cycle, `start` wins and the write is dropped.
  - `hi_we` and `lo_we` together: both registers load `wr_data`.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0; state IDLE.
- **Reset mid-operation:** abort, go to IDLE, clear HI/LO, no `done`.
- **Latency:** `start` sampled at edge N.
  - `busy`=1 after edges N through N+WIDTH.
  - FIX is entered after edge N+WIDTH.
  - At edge N+WIDTH+1, HI/LO update, `done`=1 for exactly that cycle, and `busy`=0.
  - For WIDTH=32: start at edge N, result visible after edge N+33.
- **Back-to-back ops:** a new `start` is accepted in the cycle `done` is high, so issue interval is WIDTH+1 cycles.
- **`start` while busy:** ignored, no queuing.
- **Operand capture:** operands are captured only at the accept edge; later changes on `operand_a`/`operand_b` have no effect.
- **Output registers:** `busy` and `done` are registered outputs; there is no combinational path from inputs.

## Structure
- **Shared package `mdu_pkg`:**
  - Op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - FSM state encoding: IDLE, CALC, FIX.
  - The same op constants are used by the control decoder.
- **Sub-module:** one natural sub-module, `mdu_sign_fix`. It is combinational: absolute value on entry, conditional negate on exit. It is instantiated for the 2W product and for the quotient/remainder.
- **Top level:** FSM, counter, working registers, HI/LO.

## Test plan
- **Reset values:** after reset, `hi`=0, `lo`=0, `busy`=0.
- **MULTU:** a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` exactly 33 cycles after start; `busy` high for 33 cycles.
- **MULT:** a=-3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIV:**
  - a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU by zero:** a=0x64, b=0 → LO=0xFFFFFFFF, HI=0x00000064, same latency.
- **Control sequence:**
  - MTLO 0x1234 in IDLE → `lo`=0x1234 next cycle.
  - Start MULTU 6×7; during CALC pulse `start` (DIVU 9/3) and `lo_we` (wr_data 0x5555) → both ignored, result HI=0, LO=42.
  - Repeat MULTU 6×7 and assert `rst` at cycle 10 → HI/LO=0, `busy`=0, no `done`.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op and FSM encodings for the multiply/divide unit
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate (abs on entry, sign restore on exit)
module mdu_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e state, state_next;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 is_div;
    logic                 res_sign;
    logic                 rem_sign;
    logic                 b_zero;

    logic                 signed_op;
    logic                 a_sign;
    logic                 b_sign;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_sign    = signed_op & operand_a[WIDTH-1];
    assign b_sign    = signed_op & operand_b[WIDTH-1];

    mdu_sign_fix #(.N(WIDTH)) u_abs_a (.value(operand_a), .negate(a_sign), .result(abs_a));
    mdu_sign_fix #(.N(WIDTH)) u_abs_b (.value(operand_b), .negate(b_sign), .result(abs_b));

    // acc low half holds the multiplier (consumed LSB first) or the dividend/quotient;
    // acc high half holds the partial product or the running remainder.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_step;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    always_comb begin
        acc_step = acc;
        if (!is_div) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    mdu_sign_fix #(.N(2*WIDTH)) u_fix_prod (.value(acc), .negate(res_sign), .result(prod_fixed));
    mdu_sign_fix #(.N(WIDTH)) u_fix_quo (
        .value(acc[WIDTH-1:0]), .negate(res_sign & ~b_zero), .result(quo_fixed)
    );
    mdu_sign_fix #(.N(WIDTH)) u_fix_rem (
        .value(acc[2*WIDTH-1:WIDTH]), .negate(rem_sign), .result(rem_fixed)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            b_zero   <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= {{WIDTH{1'b0}}, abs_a};
                        opb      <= abs_b;
                        is_div   <= op[1];
                        res_sign <= a_sign ^ b_sign;
                        rem_sign <= a_sign;
                        b_zero   <= (operand_b == '0);
                        cnt      <= '0;
                    end else begin
                        if (hi_we) hi <= wr_data;
                        if (lo_we) lo <= wr_data;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
